// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position, blanking and lock from hsync/vsync.
// Define VGA_SYNC_DECODER_INPUT_SYNC_EN to add a 2-flop input synchroniser.
module vga_sync_decoder #(
  parameter int   WIDTH    = 800,
  parameter int   HEIGHT   = 600,
  parameter int   HFRONT   = 24,
  parameter int   HSYNC    = 72,
  parameter int   HBACK    = 128,
  parameter int   VFRONT   = 1,
  parameter int   VSYNC    = 2,
  parameter int   VBACK    = 22,
  parameter logic POLARITY = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        hblank,
  output logic        vblank,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] htotal_meas,
  output logic [10:0] vtotal_meas
);

  localparam int HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
  localparam int VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;
  localparam logic [10:0] HTOT = 11'(HTOTAL);
  localparam logic [10:0] VTOT = 11'(VTOTAL);
  localparam logic [10:0] HBEG = 11'(HSYNC + HBACK);
  localparam logic [10:0] HEND = 11'(HSYNC + HBACK + WIDTH - 1);
  localparam logic [10:0] VBEG = 11'(VSYNC + VBACK);
  localparam logic [10:0] VEND = 11'(VSYNC + VBACK + HEIGHT - 1);
  localparam logic [10:0] CMAX = 11'h7ff;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic hs_raw, vs_raw;

`ifdef VGA_SYNC_DECODER_INPUT_SYNC_EN
  logic [1:0] hs_sync_q, hs_sync_d;
  logic [1:0] vs_sync_q, vs_sync_d;

  always_comb begin
    hs_sync_d = {hs_sync_q[0], hsync_in};
    vs_sync_d = {vs_sync_q[0], vsync_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_sync_q <= {2{~POLARITY}};
      vs_sync_q <= {2{~POLARITY}};
    end else begin
      hs_sync_q <= hs_sync_d;
      vs_sync_q <= vs_sync_d;
    end
  end

  assign hs_raw = hs_sync_q[1];
  assign vs_raw = vs_sync_q[1];
`else
  assign hs_raw = hsync_in;
  assign vs_raw = vsync_in;
`endif

  logic        hs_q, vs_q, hs_p_q, vs_p_q;
  logic        hs_d, vs_d;
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [10:0] htot_q, htot_d, vtot_q, vtot_d;
  logic        ls_q, fs_q;
  logic        h_edge, v_edge, h_bad, v_bad, lost;
  logic [10:0] h_len, v_len;

  always_comb begin
    hs_d    = (hs_raw == POLARITY);
    vs_d    = (vs_raw == POLARITY);
    h_edge  = hs_q & ~hs_p_q;
    v_edge  = vs_q & ~vs_p_q;
    h_len   = h_cnt_q + 11'd1;
    v_len   = v_cnt_q + 11'd1;
    h_bad   = (h_len != HTOT);
    v_bad   = (v_len != VTOT);
    // counter is about to saturate: no hsync for a full counter span
    lost    = (h_cnt_q == CMAX - 11'd1) & ~h_edge;
    h_cnt_d = h_cnt_q;
    if (h_edge)
      h_cnt_d = 11'd0;
    else if (h_cnt_q != CMAX)
      h_cnt_d = h_len;
    v_cnt_d = v_cnt_q;
    if (v_edge)
      v_cnt_d = 11'd0;
    else if (h_edge && v_cnt_q != CMAX)
      v_cnt_d = v_len;
    htot_d  = h_edge ? h_len : htot_q;
    vtot_d  = v_edge ? v_len : vtot_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_p_q  <= 1'b1;
      vs_p_q  <= 1'b1;
      h_cnt_q <= CMAX;
      v_cnt_q <= CMAX;
      htot_q  <= 11'd0;
      vtot_q  <= 11'd0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      hs_p_q  <= hs_q;
      vs_p_q  <= vs_q;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      htot_q  <= htot_d;
      vtot_q  <= vtot_d;
      ls_q    <= h_edge;
      fs_q    <= v_edge;
    end
  end

  state_t state_q;
  logic   herr_q, locked_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      herr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else if (lost) begin
      state_q  <= SEARCH;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (v_edge) begin
            state_q <= MEASURE;
            herr_q  <= 1'b0;
          end
        end
        MEASURE: begin
          if (v_edge) begin
            herr_q <= 1'b0;
            if (!(herr_q | (h_edge & h_bad)) && !v_bad) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end else if (h_edge && h_bad) begin
            herr_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (v_edge && (v_bad || (h_edge && h_bad))) begin
            state_q  <= MEASURE;
            herr_q   <= 1'b0;
            locked_q <= 1'b0;
          end else if (h_edge && h_bad) begin
            state_q  <= MEASURE;
            herr_q   <= 1'b1;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  logic h_act, v_act;

  always_comb begin
    h_act = (h_cnt_q >= HBEG) && (h_cnt_q <= HEND);
    v_act = (v_cnt_q >= VBEG) && (v_cnt_q <= VEND);
  end

  assign x_pos       = h_act ? 10'(h_cnt_q - HBEG) : 10'd0;
  assign y_pos       = v_act ? 10'(v_cnt_q - VBEG) : 10'd0;
  assign hblank      = ~h_act;
  assign vblank      = ~v_act;
  assign blank       = ~h_act | ~v_act | ~locked_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign htotal_meas = htot_q;
  assign vtotal_meas = vtot_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized sync stimulus with a scoreboard-checked model.
// Runs a scaled-down mode (64 x 12) so many frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int W = 40, HF = 4, HS = 8, HB = 12;
  localparam int H = 6, VF = 1, VS = 2, VB = 3;
  localparam logic POL = 1'b0;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int XB = HS + HB;
  localparam int YB = VS + VB;
`ifdef VGA_SYNC_DECODER_INPUT_SYNC_EN
  localparam int PLAT = 3;
`else
  localparam int PLAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_in = ~POL;
  logic        vsync_in = ~POL;
  logic [9:0]  x_pos, y_pos;
  logic        hblank, vblank, blank;
  logic        line_start, frame_start, locked;
  logic [10:0] htotal_meas, vtotal_meas;

  vga_sync_decoder #(
    .WIDTH(W), .HEIGHT(H),
    .HFRONT(HF), .HSYNC(HS), .HBACK(HB),
    .VFRONT(VF), .VSYNC(VS), .VBACK(VB),
    .POLARITY(POL)
  ) dut (
    .clk(clk), .reset(reset),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x_pos(x_pos), .y_pos(y_pos),
    .hblank(hblank), .vblank(vblank), .blank(blank),
    .line_start(line_start), .frame_start(frame_start),
    .locked(locked),
    .htotal_meas(htotal_meas), .vtotal_meas(vtotal_meas)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    bit ls;
    bit fs;
    int htot;
    int vtot;
    bit lk;
  } exp_t;

  exp_t q[$];

  // reference model state, advanced once per driven input cycle
  bit m_hprev, m_vprev, m_have_last, m_meas, m_fok, m_lk;
  int m_last, m_vc, m_htot, m_vtot;

  task automatic model_reset();
    m_hprev = 1'b0;
    m_vprev = 1'b0;
    m_have_last = 1'b0;
    m_meas = 1'b0;
    m_fok = 1'b1;
    m_lk = 1'b0;
    m_vc = 2047;
    m_htot = 0;
    m_vtot = 0;
    q.delete();
  endtask

  task automatic model_step(input int n, input bit he, input bit ve);
    exp_t e;
    int hc;
    if (he) begin
      hc = 2047;
      if (m_have_last) begin
        if (n - m_last >= 2048) begin
          m_meas = 1'b0;
          m_lk = 1'b0;
        end
        hc = (n - m_last - 1 > 2047) ? 2047 : n - m_last - 1;
      end
      m_htot = (hc + 1) % 2048;
      m_last = n;
      m_have_last = 1'b1;
      if (hc + 1 != HT) begin
        m_fok = 1'b0;
        m_lk = 1'b0;
      end
    end
    if (ve) begin
      m_vtot = (m_vc + 1) % 2048;
      m_lk = m_meas && m_fok && (m_vc + 1 == VT);
      m_meas = 1'b1;
      m_fok = 1'b1;
      m_vc = 0;
    end else if (he) begin
      m_vc = (m_vc < 2047) ? m_vc + 1 : 2047;
    end
    if (he || ve) begin
      e.cyc = n + PLAT;
      e.ls = he;
      e.fs = ve;
      e.htot = m_htot;
      e.vtot = m_vtot;
      e.lk = m_lk;
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit h, input bit v);
    int n;
    @(negedge clk);
    hsync_in = h ? POL : ~POL;
    vsync_in = v ? POL : ~POL;
    n = cyc + 1;
    model_step(n, h && !m_hprev, v && !m_vprev);
    m_hprev = h;
    m_vprev = v;
  endtask

  task automatic frame(input int nl, input int bad, input int blen);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == bad) ? blen : HT;
      for (int i = 0; i < len; i++) drive(i < HS, l < VS);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x_pos"}, int'(x_pos), 0);
    chk({tag, "_y_pos"}, int'(y_pos), 0);
    chk({tag, "_hblank"}, int'(hblank), 1);
    chk({tag, "_vblank"}, int'(vblank), 1);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_htotal"}, int'(htotal_meas), 0);
    chk({tag, "_vtotal"}, int'(vtotal_meas), 0);
  endtask

  task automatic do_reset(input int ncyc, input string tag);
    @(negedge clk);
    reset = 1'b1;
    hsync_in = ~POL;
    vsync_in = ~POL;
    repeat (ncyc) @(posedge clk);
    #2;
    chk_reset_vals(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // monitor: pops one expectation per presented pulse
  bit lk_pend = 1'b0;
  bit lk_exp = 1'b0;
  bit anchored = 1'b0;
  int a_ls = 0;
  int ln = 0;

  always @(posedge clk) begin
    exp_t e;
    int hx, ex, ey;
    bit ehb, evb;
    #2;
    if (reset) begin
      lk_pend = 1'b0;
      anchored = 1'b0;
    end else begin
      if (lk_pend) begin
        chk("locked_after_pulse", int'(locked), int'(lk_exp));
        lk_pend = 1'b0;
      end
      if (line_start || frame_start) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("line_start", int'(line_start), int'(e.ls));
          chk("frame_start", int'(frame_start), int'(e.fs));
          chk("htotal_meas", int'(htotal_meas), e.htot);
          chk("vtotal_meas", int'(vtotal_meas), e.vtot);
          lk_exp = e.lk;
          lk_pend = 1'b1;
          a_ls = e.cyc;
          ln = e.fs ? 0 : ln + 1;
          anchored = 1'b1;
        end
      end
      if (locked && anchored) begin
        hx = cyc - a_ls;
        ehb = !(hx >= XB && hx <= XB + W - 1);
        evb = !(ln >= YB && ln <= YB + H - 1);
        ex = ehb ? 0 : hx - XB;
        ey = evb ? 0 : ln - YB;
        chk("hblank", int'(hblank), int'(ehb));
        chk("vblank", int'(vblank), int'(evb));
        chk("blank", int'(blank), int'(ehb | evb));
        chk("x_pos", int'(x_pos), ex);
        chk("y_pos", int'(y_pos), ey);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, bl, d;
    model_reset();
    do_reset(3, "reset");
    repeat ($urandom_range(3, 20)) drive(1'b0, 1'b0);

    // clean frames: lock at the second frame edge
    repeat (3) frame(VT, -1, HT);

    // random perturbations of line length and frame length
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 3);
      if (r == 2) begin
        d = $urandom_range(1, 6);
        bl = ($urandom_range(0, 1) == 1) ? HT + d : HT - d;
        frame(VT, $urandom_range(0, VT - 1), bl);
      end else if (r == 3) begin
        frame(($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1, -1, HT);
      end else begin
        frame(VT, -1, HT);
      end
    end
    repeat (2) frame(VT, -1, HT);

    // stretched line while locked, then relock
    frame(VT, 3, HT + 6);
    repeat (2) frame(VT, -1, HT);

    // hsync loss
    repeat (2100) drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk("loss_locked", int'(locked), 0);
    chk("loss_blank", int'(blank), 1);
    repeat (3) frame(VT, -1, HT);

    // reset mid-frame while locked
    frame(7, -1, HT);
    for (int i = 0; i < 30; i++) drive(i < HS, 1'b0);
    do_reset(2, "midreset");
    repeat ($urandom_range(3, 20)) drive(1'b0, 1'b0);
    repeat (3) frame(VT, -1, HT);
    frame(2, -1, HT);

    repeat (8) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
